// File: rtl/bm_ctrl_pkg.sv
// Shared types and helpers for the Box-Muller AWGN sequencer.
// Optional build macro used by this slice: BM_CTRL_DROP_CNT_EN (adds a dropped-pair counter).
package bm_ctrl_pkg;

  localparam int DW_DEF    = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Pointer width for a FIFO of the given depth; never below 1 bit.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/bm_awgn_ctrl_if.sv
// Output sample stream of the AWGN sequencer.
// Handshake: a word transfers on a rising clk edge where out_valid && out_ready; out_data and
// out_last are held stable while out_valid is high and out_ready is low; out_valid does not depend on out_ready.
interface bm_awgn_ctrl_if #(
  parameter int DW = 16
) ();
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/bm_ctrl_fifo.sv
// Synchronous FIFO: two words pushed per cycle, one popped; each entry carries a last tag.
// When empty, the read port shows the most recently popped word.
module bm_ctrl_fifo
  import bm_ctrl_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic          last1,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          dout_last,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_TWO = (AW+1)'(2);

  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_idx;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign rd_idx = empty ? (rd_ptr - P_ONE) : rd_ptr;
  assign dout      = mem[rd_idx][DW-1:0];
  assign dout_last = mem[rd_idx][DW];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]         <= {1'b0, din0};
        mem[wr_ptr + P_ONE] <= {last1, din1};
        wr_ptr              <= wr_ptr + AW'(2);
      end
      if (do_pop) rd_ptr <= rd_ptr + P_ONE;
      case ({push, do_pop})
        2'b10:   count <= count + C_TWO;
        2'b11:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bm_awgn_ctrl.sv
// Box-Muller AWGN sequencer: seed-load, run and drain phases; serialises (x0, x1) pairs
// into one stream. Optional macro BM_CTRL_DROP_CNT_EN adds the drop_cnt output.
module bm_awgn_ctrl
  import bm_ctrl_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int SEED_CYCLES = 4,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      seed1,
  input  logic [31:0]      seed2,
  input  logic [CNT_W-1:0] num_pairs,
  output logic             bm_reset,
  output logic [31:0]      bm_seed1,
  output logic [31:0]      bm_seed2,
  input  logic             bm_v,
  input  logic [DW-1:0]    bm_x0,
  input  logic [DW-1:0]    bm_x1,
  bm_awgn_ctrl_if.master   out_if,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output state_t           state_dbg
`ifdef BM_CTRL_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  localparam int AW  = ptr_w(FIFO_DEPTH);
  localparam int SCW = ptr_w(SEED_CYCLES) + 1;
  localparam logic [AW:0]      ROOM_MAX = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [SCW-1:0]   SEED_END = SCW'(SEED_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] num_r;
  logic [CNT_W-1:0] pair_cnt;
  logic [SCW-1:0]   seed_cnt;
  logic [AW:0]      fifo_cnt;
  logic             fifo_empty;
  logic             room;
  logic             accept;
  logic             drop;
  logic             final_acc;

  // Free space is judged on occupancy before this cycle's pop.
  assign room      = (fifo_cnt <= ROOM_MAX);
  assign accept    = (state == RUN) && bm_v && room;
  assign drop      = (state == RUN) && bm_v && !room;
  assign final_acc = accept && (num_r != '0) && (pair_cnt == num_r - CNT_ONE);

  assign out_if.out_valid = !fifo_empty;
  assign state_dbg        = state;

  bm_ctrl_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .din0      (bm_x0),
    .din1      (bm_x1),
    .last1     (final_acc),
    .pop       (out_if.out_valid && out_if.out_ready),
    .dout      (out_if.out_data),
    .dout_last (out_if.out_last),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bm_reset <= 1'b1;
      bm_seed1 <= '0;
      bm_seed2 <= '0;
      num_r    <= '0;
      pair_cnt <= '0;
      seed_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
`ifdef BM_CTRL_DROP_CNT_EN
      drop_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bm_seed1 <= seed1;
            bm_seed2 <= seed2;
            num_r    <= num_pairs;
            pair_cnt <= '0;
            seed_cnt <= '0;
            overflow <= 1'b0;
`ifdef BM_CTRL_DROP_CNT_EN
            drop_cnt <= '0;
`endif
            busy     <= 1'b1;
            state    <= SEED;
          end
        end
        SEED: begin
          if (seed_cnt == SEED_END) begin
            bm_reset <= 1'b0;
            state    <= RUN;
          end else begin
            seed_cnt <= seed_cnt + SCW'(1);
          end
        end
        RUN: begin
          if (accept && (pair_cnt != '1)) pair_cnt <= pair_cnt + CNT_ONE;
          if (drop) begin
            overflow <= 1'b1;
`ifdef BM_CTRL_DROP_CNT_EN
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
`endif
          end
          // A final pair arriving with stop is still kept; both paths lead to DRAIN.
          if (final_acc || stop) begin
            bm_reset <= 1'b1;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bm_awgn_ctrl.sv
// Directed bench for bm_awgn_ctrl: expected words go into a queue at issue time and a
// monitor compares them against every accepted output word.
module tb_bm_awgn_ctrl;
  import bm_ctrl_pkg::*;

  localparam int DW    = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic [31:0]      seed1;
  logic [31:0]      seed2;
  logic [CNT_W-1:0] num_pairs;
  logic             bm_reset;
  logic [31:0]      bm_seed1;
  logic [31:0]      bm_seed2;
  logic             bm_v;
  logic [DW-1:0]    bm_x0;
  logic [DW-1:0]    bm_x1;
  logic             busy;
  logic             done;
  logic             overflow;
  state_t           state_dbg;
`ifdef BM_CTRL_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt;
`endif

  bm_awgn_ctrl_if #(.DW(DW)) ifc ();

  bm_awgn_ctrl #(
    .DW          (DW),
    .FIFO_DEPTH  (4),
    .SEED_CYCLES (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .seed1     (seed1),
    .seed2     (seed2),
    .num_pairs (num_pairs),
    .bm_reset  (bm_reset),
    .bm_seed1  (bm_seed1),
    .bm_seed2  (bm_seed2),
    .bm_v      (bm_v),
    .bm_x0     (bm_x0),
    .bm_x1     (bm_x1),
    .out_if    (ifc.master),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .state_dbg (state_dbg)
`ifdef BM_CTRL_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [DW:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_pop_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_word: got unexpected 0x%0h, expected no word", {ifc.out_last, ifc.out_data});
        end else begin
          check("out_word", 64'({ifc.out_last, ifc.out_data}), 64'(exp_q.pop_front()));
        end
        pops++;
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] s1, input logic [31:0] s2, input logic [CNT_W-1:0] n);
    seed1     = s1;
    seed2     = s2;
    num_pairs = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Counts cycles with bm_reset high after start; leaves the bench in the first RUN cycle.
  task automatic wait_seed();
    int hold = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bm_reset) break;
      hold++;
      tick();
    end
    check("seed_hold_cycles", 64'(hold), 64'd4);
  endtask

  task automatic send_pair(input int idx, input bit acc, input bit last, input int gap, input bit with_stop);
    bm_v  = 1'b1;
    bm_x0 = 16'h1100 + DW'(idx);
    bm_x1 = 16'h2200 + DW'(idx);
    stop  = with_stop;
    if (acc) begin
      exp_q.push_back({1'b0, bm_x0});
      exp_q.push_back({last, bm_x1});
    end
    tick();
    bm_v = 1'b0;
    stop = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < max_cyc) begin
      tick();
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done within %0d cycles, expected done", name, max_cyc);
    end
  endtask

  int p0;
  int d0;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; seed1 = '0; seed2 = '0; num_pairs = '0;
    bm_v = 1'b0; bm_x0 = '0; bm_x1 = '0; ifc.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset values
    check("rst_bm_reset", 64'(bm_reset), 64'd1);
    check("rst_seed1", 64'(bm_seed1), 64'd0);
    check("rst_seed2", 64'(bm_seed2), 64'd0);
    check("rst_valid", 64'(ifc.out_valid), 64'd0);
    check("rst_last", 64'(ifc.out_last), 64'd0);
    check("rst_busy_done_ovf", 64'({busy, done, overflow}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));

    // 1: finite run of 8 pairs, consumer always ready
    ifc.out_ready = 1'b1;
    p0 = pops; d0 = done_cnt;
    do_start(32'h67580, 32'h70385, 16'd8);
    check("t1_seed1", 64'(bm_seed1), 64'h67580);
    check("t1_seed2", 64'(bm_seed2), 64'h70385);
    check("t1_busy", 64'(busy), 64'd1);
    wait_seed();
    for (int i = 0; i < 8; i++) send_pair(i, 1'b1, i == 7, 1, 1'b0);
    wait_done("t1_done", 100);
    // done rises on the edge after the edge that popped the last word
    check("t1_done_timing", 64'(done_cyc), 64'(last_pop_cyc + 2));
    repeat (3) tick();
    check("t1_words", 64'(pops - p0), 64'd16);
    check("t1_done_count", 64'(done_cnt - d0), 64'd1);
    check("t1_overflow", 64'(overflow), 64'd0);
    check("t1_idle", 64'({busy, bm_reset}), 64'b01);

    // 2: consumer stalled; 2 pairs fill the FIFO, 6 dropped
    ifc.out_ready = 1'b0;
    p0 = pops;
    do_start(32'h67580, 32'h70385, 16'd8);
    wait_seed();
    for (int i = 0; i < 8; i++) send_pair(i, i < 2, 1'b0, 0, 1'b0);
    tick();
    check("t2_overflow", 64'(overflow), 64'd1);
`ifdef BM_CTRL_DROP_CNT_EN
    check("t2_drop_cnt", 64'(drop_cnt), 64'd6);
`endif
    check("t2_state_run", 64'(state_dbg), 64'(RUN));
    check("t2_valid", 64'(ifc.out_valid), 64'd1);
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 20 && ifc.out_valid; i++) tick();
    check("t2_fifo_words", 64'(pops - p0), 64'd4);
    for (int i = 8; i < 14; i++) send_pair(i, 1'b1, i == 13, 1, 1'b0);
    wait_done("t2_done", 100);
    tick();
    check("t2_overflow_sticky", 64'(overflow), 64'd1);
    check("t2_words", 64'(pops - p0), 64'd16);

    // 3: continuous mode, stop after 10 pairs
    p0 = pops; d0 = done_cnt;
    do_start(32'h1234, 32'h5678, 16'd0);
    check("t3_overflow_cleared", 64'(overflow), 64'd0);
    wait_seed();
    for (int i = 0; i < 10; i++) send_pair(20 + i, 1'b1, 1'b0, 1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("t3_done", 100);
    repeat (3) tick();
    check("t3_words", 64'(pops - p0), 64'd20);
    check("t3_done_count", 64'(done_cnt - d0), 64'd1);

    // 4: stop coincides with the final pair
    p0 = pops; d0 = done_cnt;
    do_start(32'hA5A5, 32'h5A5A, 16'd8);
    wait_seed();
    for (int i = 0; i < 8; i++) send_pair(40 + i, 1'b1, i == 7, 1, i == 7);
    wait_done("t4_done", 100);
    repeat (5) tick();
    check("t4_words", 64'(pops - p0), 64'd16);
    check("t4_done_count", 64'(done_cnt - d0), 64'd1);

    // 5: reset mid-run with 3 words held
    ifc.out_ready = 1'b0;
    d0 = done_cnt;
    do_start(32'h1, 32'h2, 16'd0);
    wait_seed();
    send_pair(60, 1'b1, 1'b0, 0, 1'b0);
    send_pair(61, 1'b1, 1'b0, 0, 1'b0);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("t5_state", 64'(state_dbg), 64'(IDLE));
    check("t5_valid", 64'(ifc.out_valid), 64'd0);
    check("t5_bm_reset", 64'(bm_reset), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    repeat (3) tick();
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);

    // 6: stop in IDLE and start while busy are ignored
    ifc.out_ready = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t6_stop_idle", 64'({busy, state_dbg}), 64'({1'b0, IDLE}));
    p0 = pops; d0 = done_cnt;
    do_start(32'hCAFE, 32'hBEEF, 16'd4);
    tick();
    do_start(32'hDEAD, 32'hF00D, 16'd2);
    check("t6_seed1_kept", 64'(bm_seed1), 64'hCAFE);
    check("t6_state_seed", 64'(state_dbg), 64'(SEED));
    for (int i = 0; i < 10 && state_dbg != RUN; i++) tick();
    for (int i = 0; i < 4; i++) send_pair(80 + i, 1'b1, i == 3, 1, 1'b0);
    wait_done("t6_done", 100);
    repeat (3) tick();
    check("t6_words", 64'(pops - p0), 64'd8);
    check("t6_done_count", 64'(done_cnt - d0), 64'd1);
    check("t6_seed2_kept", 64'(bm_seed2), 64'hBEEF);

    // final report
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
